// File: rtl/subcarrier_demap.sv
// subcarrier_demap: drops DC/guard/pilot bins and emits each data subcarrier as saturated Re/Im soft bytes
module subcarrier_demap #(
  parameter int SHIFT = 6,
  parameter int NFFT = 256
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] DAT_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  output logic        ACK_O,
  output logic [7:0]  DAT_O,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I
);
  localparam int CW = $clog2(NFFT);
  typedef enum logic [1:0] {S_IN, S_RE, S_IM} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] bin_cnt_q, bin_cnt_d;
  logic [7:0] im_q, im_d, dat_q, dat_d;
  logic stb_q, stb_d, cyc_q, cyc_d;
  logic acc;
  logic unused;
  function automatic logic is_data(input logic [CW-1:0] k);
    return k != 0 && (k <= 100 || k >= 156) &&
           !(k inside {13, 38, 63, 88, 168, 193, 218, 243});
  endfunction
  function automatic logic [7:0] sat(input logic [15:0] x);
    logic signed [15:0] y;
    y = $signed(x) >>> SHIFT;
    return y > 16'sd127 ? 8'h7f : y < -16'sd128 ? 8'h80 : y[7:0];
  endfunction
  assign unused = WE_I;
  assign acc = state_q == S_IN && CYC_I && STB_I && !RST_I;
  assign ACK_O = acc;
  assign DAT_O = dat_q;
  assign CYC_O = cyc_q;
  assign STB_O = stb_q;
  assign WE_O = stb_q;
  // Bin counting, byte conversion and the Re/Im output sequencing
  always_comb begin
    state_d = state_q;
    bin_cnt_d = CYC_I ? bin_cnt_q : '0;
    im_d = im_q;
    dat_d = dat_q;
    stb_d = stb_q;
    cyc_d = (state_q == S_IN && !CYC_I) ? 1'b0 : cyc_q;
    if (acc) begin
      bin_cnt_d = bin_cnt_q + 1'b1;
      if (is_data(bin_cnt_q)) begin
        dat_d = sat(DAT_I[15:0]);
        im_d = sat(DAT_I[31:16]);
        stb_d = 1'b1;
        cyc_d = 1'b1;
        state_d = S_RE;
      end
    end else if (state_q == S_RE && ACK_I) begin
      dat_d = im_q;
      state_d = S_IM;
    end else if (state_q == S_IM && ACK_I) begin
      stb_d = 1'b0;
      state_d = S_IN;
    end
  end
  // State and output registers; reset drops any pair in flight
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= S_IN;
      bin_cnt_q <= '0;
      im_q <= '0;
      dat_q <= '0;
      stb_q <= 1'b0;
      cyc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_cnt_q <= bin_cnt_d;
      im_q <= im_d;
      dat_q <= dat_d;
      stb_q <= stb_d;
      cyc_q <= cyc_d;
    end
  end
endmodule

// File: tb/tb_subcarrier_demap.sv
// tb_subcarrier_demap: scoreboard bench for subcarrier_demap
module tb_subcarrier_demap;
  logic CLK_I = 0, RST_I = 1, CYC_I = 0, STB_I = 0, WE_I = 0, ACK_I = 1;
  logic [31:0] DAT_I = 0;
  logic ACK_O, CYC_O, STB_O, WE_O;
  logic [7:0] DAT_O;
  int pass_cnt = 0, total = 0, bytes = 0, cyc = 0, ack_mode = 0;
  logic [7:0] q[$];
  logic prev_stall = 0;
  logic [7:0] prev_dat = 0;

  subcarrier_demap #(.SHIFT(6), .NFFT(256)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I), .STB_I(STB_I),
    .WE_I(WE_I), .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O),
    .WE_O(WE_O), .ACK_I(ACK_I)
  );

  always #5 CLK_I = ~CLK_I;
  always @(posedge CLK_I) cyc++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic bit tb_data(input int k);
    int pil[8] = '{13, 38, 63, 88, 168, 193, 218, 243};
    if (k == 0 || (k > 100 && k < 156)) return 0;
    foreach (pil[i]) if (pil[i] == k) return 0;
    return 1;
  endfunction

  // ACK_I: 0 = always high, 1 = one low then two high, 2 = held low
  initial forever begin
    @(posedge CLK_I);
    #1;
    ACK_I = ack_mode == 0 ? 1'b1 : ack_mode == 1 ? (cyc % 3 != 0) : 1'b0;
  end

  // Monitor: pops expected bytes on each output transfer, checks stall stability
  always @(negedge CLK_I) begin
    if (RST_I) prev_stall = 0;
    else begin
      if (prev_stall) begin
        check("stall_stb", int'(STB_O), 1);
        check("stall_dat", int'(DAT_O), int'(prev_dat));
      end
      if (STB_O) check("ack_o_busy", int'(ACK_O), 0);
      if (STB_O && ACK_I) begin
        if (q.size() == 0) check("unexpected_byte", 1, 0);
        else check("byte", int'($signed(DAT_O)), int'($signed(q.pop_front())));
        bytes++;
      end
      prev_stall = STB_O && !ACK_I;
      prev_dat = DAT_O;
    end
  end

  task automatic send(input logic [15:0] re, input logic [15:0] im, input bit d,
                      input logic [7:0] er, input logic [7:0] ei);
    int n = 0;
    DAT_I = {im, re};
    CYC_I = 1;
    STB_I = 1;
    #1;
    while (!ACK_O && n < 50) begin
      @(negedge CLK_I);
      #1;
      n++;
    end
    if (!ACK_O) check("accept_timeout", 0, 1);
    else if (d) begin
      q.push_back(er);
      q.push_back(ei);
    end
    @(negedge CLK_I);
  endtask

  task automatic sym(input int n);
    for (int i = 0; i < n; i++) begin
      int k = i % 256;
      send(16'(k * 64), 16'(-k * 64), tb_data(k), 8'(k > 127 ? 127 : k), 8'(k > 127 ? -128 : -k));
    end
  endtask

  task automatic end_frame();
    int n = 0;
    CYC_I = 0;
    STB_I = 0;
    while ((CYC_O || STB_O) && n < 50) begin
      @(negedge CLK_I);
      n++;
    end
    check("cyc_o_fall", int'(CYC_O), 0);
    check("pairs_done", q.size(), 0);
  endtask

  task automatic full_symbol(input string tag);
    int b0 = bytes, c0 = cyc, n = 0;
    sym(256);
    while (STB_O && n < 20) begin
      @(negedge CLK_I);
      n++;
    end
    check({tag, "_cycles"}, cyc - c0, 640);
    end_frame();
    check({tag, "_bytes"}, bytes - b0, 384);
  endtask

  initial begin
    int b0;
    repeat (3) @(negedge CLK_I);
    check("rst_ack", int'(ACK_O), 0);
    check("rst_dat", int'(DAT_O), 0);
    check("rst_cyc", int'(CYC_O), 0);
    check("rst_stb", int'(STB_O), 0);
    check("rst_we", int'(WE_O), 0);
    RST_I = 0;
    @(negedge CLK_I);
    full_symbol("t1");
    send(16'h0000, 16'h0000, 0, 8'h00, 8'h00);
    send(16'h7FFF, 16'h8000, 1, 8'h7F, 8'h80);
    send(16'hFFFF, 16'h003F, 1, 8'hFF, 8'h00);
    send(16'h1FC0, 16'hE000, 1, 8'h7F, 8'h80);
    send(16'h2000, 16'hDFC0, 1, 8'h7F, 8'h80);
    end_frame();
    ack_mode = 1;
    b0 = bytes;
    sym(256);
    end_frame();
    check("bp_bytes", bytes - b0, 384);
    ack_mode = 0;
    b0 = bytes;
    sym(512);
    end_frame();
    check("wrap_bytes", bytes - b0, 768);
    sym(51);
    end_frame();
    check("drop_stb_low", int'(STB_O), 0);
    b0 = bytes;
    sym(4);
    end_frame();
    check("refr_bytes", bytes - b0, 6);
    ack_mode = 2;
    repeat (2) @(negedge CLK_I);
    send(16'h0000, 16'h0000, 0, 8'h00, 8'h00);
    send(16'h0040, 16'hFFC0, 0, 8'h00, 8'h00);
    check("rre_stb", int'(STB_O), 1);
    #2 RST_I = 1;
    #1;
    check("rre_ack", int'(ACK_O), 0);
    check("rre_dat", int'(DAT_O), 0);
    check("rre_cyc", int'(CYC_O), 0);
    check("rre_stb0", int'(STB_O), 0);
    check("rre_we", int'(WE_O), 0);
    CYC_I = 0;
    STB_I = 0;
    @(negedge CLK_I);
    #2 RST_I = 0;
    ack_mode = 0;
    repeat (2) @(negedge CLK_I);
    full_symbol("t6");
    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
